// File: rtl/gcnt_rx_if.sv
// Sample bus between a Gray-coded count source and gcnt_rx.
// master: the side presenting samples and observing results.
// slave:  the receiver itself.
interface gcnt_rx_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] bin_count;
    logic             valid;
    logic [WIDTH-1:0] step;
    logic             up;
    logic             down;
    logic             wrap;
    logic             err;
    logic [15:0]      err_cnt;
    logic             locked;

    modport master (
        output ena, gray_in,
        input  bin_count, valid, step, up, down, wrap, err, err_cnt, locked
    );

    modport slave (
        input  ena, gray_in,
        output bin_count, valid, step, up, down, wrap, err, err_cnt, locked
    );
endinterface

// File: rtl/gcnt_rx.sv
// Gray-code count receiver.
// Captures a Gray-coded count, decodes it to binary and classifies each
// new sample against the previous one as hold, up, down or illegal jump.
// Two pipeline stages: capture (g_q/v1), then decode/classify into the
// registered outputs. The first sample after reset only establishes the
// reference value; every later sample is classified.
module gcnt_rx #(
    parameter int WIDTH    = 8,
    parameter int MAX_STEP = 1
) (
    input  logic       clk,
    input  logic       sclr,
    gcnt_rx_if.slave   bus
);

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX_STEP_W = WIDTH'(MAX_STEP);
    // Smallest unsigned encoding that still means a legal backward step.
    localparam logic [WIDTH-1:0] NEG_MAX_W  = '0 - MAX_STEP_W;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Stage 1 state
    logic [WIDTH-1:0] g_q;
    logic             v1;

    // Reference value and FSM state
    logic [WIDTH-1:0] prev;
    state_t           state_q;
    state_t           state_d;

    // Stage 2 combinational results
    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] step_raw;
    logic             is_hold;
    logic             is_up;
    logic             is_down;
    logic             is_err;
    logic             is_wrap;

    // Next values for the registered outputs
    logic [WIDTH-1:0] step_d;
    logic             valid_d;
    logic             up_d;
    logic             down_d;
    logic             wrap_d;
    logic             err_d;

    // Output registers
    logic [WIDTH-1:0] bin_count_q;
    logic [WIDTH-1:0] step_q;
    logic             valid_q;
    logic             up_q;
    logic             down_q;
    logic             wrap_q;
    logic             err_q;
    logic [15:0]      err_cnt_q;

    // Stage 1: capture the Gray sample whenever the strobe is high.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (sclr) begin
            g_q <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= bus.ena;
            if (bus.ena) begin
                g_q <= bus.gray_in;
            end
        end
    end

    // Stage 2 datapath: decode the captured sample and classify its step.
    // NOTE: every signal gets a default at the top of a combinational block,
    // so no path through it can leave a value unassigned and infer a latch.
    always_comb begin
        bin_new  = gray_to_bin(g_q);
        step_raw = bin_new - prev;
        is_hold  = (step_raw == '0);
        is_up    = !is_hold && (step_raw <= MAX_STEP_W);
        is_down  = !is_hold && (step_raw >= NEG_MAX_W);
        // Anything else, including the most negative value, is an illegal jump.
        is_err   = !is_hold && !is_up && !is_down;
        is_wrap  = (is_up && (bin_new < prev)) || (is_down && (bin_new > prev));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the first processed sample locks; only reset unlocks.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY:  if (v1) state_d = ST_LOCKED;
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_EMPTY;
        endcase
    end

    // FSM outputs: the reference sample reports step 0 and no flags.
    always_comb begin
        valid_d = v1;
        step_d  = '0;
        up_d    = 1'b0;
        down_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                step_d = '0;
            end
            ST_LOCKED: begin
                step_d = step_raw;
                up_d   = v1 && is_up;
                down_d = v1 && is_down;
                wrap_d = v1 && is_wrap;
                err_d  = v1 && is_err;
            end
            default: begin
                step_d = '0;
            end
        endcase
    end

    // Stage 2 registers: outputs and reference update only on a processed sample.
    always_ff @(posedge clk) begin
        if (sclr) begin
            prev        <= '0;
            bin_count_q <= '0;
            step_q      <= '0;
            valid_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            valid_q <= valid_d;
            up_q    <= up_d;
            down_q  <= down_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            if (v1) begin
                // Error samples also become the new reference so the block resyncs.
                prev        <= bin_new;
                bin_count_q <= bin_new;
                step_q      <= step_d;
            end
        end
    end

    // Saturating count of illegal jumps, updated on the same edge as err.
    always_ff @(posedge clk) begin
        if (sclr) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    // Drive the bus from the registered state.
    assign bus.bin_count = bin_count_q;
    assign bus.step      = step_q;
    assign bus.valid     = valid_q;
    assign bus.up        = up_q;
    assign bus.down      = down_q;
    assign bus.wrap      = wrap_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_gcnt_rx.sv
// Self-checking bench for gcnt_rx (WIDTH=4, MAX_STEP=1): directed scenarios,
// error-counter saturation and randomized traffic against a reference model.
module tb_gcnt_rx;

    localparam int W    = 4;
    localparam int MS   = 1;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic clk = 1'b0;
    logic sclr;

    always #5 clk = ~clk;

    gcnt_rx_if #(.WIDTH(W)) bus ();

    gcnt_rx #(.WIDTH(W), .MAX_STEP(MS)) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pend_v, m_pend_g;
    int m_locked, m_prev;
    int m_bin, m_step, m_valid, m_up, m_down, m_wrap, m_err, m_errcnt;
    int last_bin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    // Binary value is the XOR of the Gray word shifted right by every amount.
    function automatic int ungray(input int g);
        int b = 0;
        for (int s = g; s != 0; s = s >> 1) b = b ^ s;
        return b & MASK;
    endfunction

    task automatic model_reset();
        m_pend_v = 0; m_pend_g = 0; m_locked = 0; m_prev = 0;
        m_bin = 0; m_step = 0; m_valid = 0; m_up = 0; m_down = 0;
        m_wrap = 0; m_err = 0; m_errcnt = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit r, input bit e, input int g);
        int b, d, s;
        if (r) begin
            model_reset();
            return;
        end
        m_valid = 0; m_up = 0; m_down = 0; m_wrap = 0; m_err = 0;
        if (m_pend_v != 0) begin
            b = ungray(m_pend_g);
            d = (b - m_prev) & MASK;
            s = (d >= HALF) ? d - (1 << W) : d;
            m_valid = 1;
            if (m_locked == 0) begin
                m_step   = 0;
                m_locked = 1;
            end else begin
                m_step = d;
                m_up   = (s >= 1 && s <= MS) ? 1 : 0;
                m_down = (s <= -1 && s >= -MS) ? 1 : 0;
                m_err  = (s != 0 && m_up == 0 && m_down == 0) ? 1 : 0;
                m_wrap = ((m_up != 0 && b < m_prev) || (m_down != 0 && b > m_prev)) ? 1 : 0;
                if (m_err != 0 && m_errcnt < 65535) m_errcnt++;
            end
            m_prev = b;
            m_bin  = b;
        end
        m_pend_v = e ? 1 : 0;
        if (e) m_pend_g = g & MASK;
    endtask

    task automatic check_all();
        check("bin_count", 32'(bus.bin_count), 32'(m_bin));
        check("step",      32'(bus.step),      32'(m_step));
        check("valid",     32'(bus.valid),     32'(m_valid));
        check("up",        32'(bus.up),        32'(m_up));
        check("down",      32'(bus.down),      32'(m_down));
        check("wrap",      32'(bus.wrap),      32'(m_wrap));
        check("err",       32'(bus.err),       32'(m_err));
        check("err_cnt",   32'(bus.err_cnt),   32'(m_errcnt));
        check("locked",    32'(bus.locked),    32'(m_locked));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare after it.
    task automatic cyc(input bit r, input bit e, input int g, input bit chk);
        @(negedge clk);
        sclr        = r;
        bus.ena     = e;
        bus.gray_in = W'(g);
        @(posedge clk);
        model_edge(r, e, g);
        #1;
        if (chk) check_all();
    endtask

    task automatic feed(input int g);
        cyc(1'b0, 1'b1, g, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 0, 1'b1);
    endtask

    initial begin
        sclr        = 1'b1;
        bus.ena     = 1'b0;
        bus.gray_in = '0;
        model_reset();

        // Reset and first sample
        do_reset();
        do_reset();
        feed(4'b0111);
        idle();
        check("first_bin",    32'(bus.bin_count), 32'd5);
        check("first_valid",  32'(bus.valid),     32'd1);
        check("first_locked", 32'(bus.locked),    32'd1);

        // Count up with wrap
        do_reset();
        feed(4'b1011); feed(4'b1001); feed(4'b1000); feed(4'b0000);
        idle();
        check("upwrap_bin",  32'(bus.bin_count), 32'd0);
        check("upwrap_wrap", 32'(bus.wrap),      32'd1);

        // Count down across zero
        do_reset();
        feed(4'b0001); feed(4'b0000); feed(4'b1000);
        idle();
        check("dnwrap_step", 32'(bus.step), 32'hF);
        check("dnwrap_down", 32'(bus.down), 32'd1);

        // Illegal jump then resync
        do_reset();
        feed(4'b0010); feed(4'b1101); feed(4'b1111);
        check("jump_err",  32'(bus.err),     32'd1);
        check("jump_step", 32'(bus.step),    32'h6);
        check("jump_cnt",  32'(bus.err_cnt), 32'd1);
        idle();
        check("resync_up", 32'(bus.up), 32'd1);

        // Gaps and hold, then +7 and -8 jumps
        do_reset();
        feed(4'b0110); idle(); idle(); feed(4'b0110); idle(); idle();
        feed(4'b1000); feed(4'b0101); idle();
        check("plus7_err", 32'(bus.err), 32'd1);
        do_reset();
        feed(4'b1010); feed(4'b0110); idle();
        check("minus8_step", 32'(bus.step), 32'h8);
        check("minus8_err",  32'(bus.err),  32'd1);

        // Reset priority and mid-operation reset
        do_reset();
        cyc(1'b1, 1'b1, 4'b0011, 1'b1);
        idle();
        check("rst_prio_valid",  32'(bus.valid),  32'd0);
        check("rst_prio_locked", 32'(bus.locked), 32'd0);
        feed(4'b0011);
        cyc(1'b1, 1'b0, 0, 1'b1);
        idle();
        check("rst_mid_valid", 32'(bus.valid), 32'd0);

        // Saturation: alternating 0 and 8 gives a -8 step on every sample
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            cyc(1'b0, 1'b1, gray((i % 2) * 8), 1'b0);
        end
        idle();
        check("sat_cnt", 32'(bus.err_cnt), 32'hFFFF);
        for (int i = 0; i < 4; i++) feed(gray((i % 2) * 8));
        idle();
        check("sat_hold", 32'(bus.err_cnt), 32'hFFFF);

        // Randomized traffic: mostly small steps around the last value, some jumps
        do_reset();
        last_bin = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, e;
            int b;
            r = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) b = int'($urandom_range(0, MASK));
            else b = (last_bin + int'($urandom_range(0, 2)) - 1) & MASK;
            if (e) last_bin = b;
            cyc(r, e, gray(b), 1'b1);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcnt_rx.md
# gcnt_rx

Gray-code count receiver: samples a Gray-coded count produced by `gcnt` or an equivalent source, decodes it to binary, and classifies each new sample against the previous one as up, down, hold or illegal jump. It sits on the consuming side of a Gray-coded counter or pointer, for example a position or pointer bus already in the local clock domain. It drives a decoded count, a signed step, direction and wrap flags, and a saturating error counter.

## Interface
- `WIDTH`, 8, count width in bits; minimum 2.
- `MAX_STEP`, 1, largest legal |step| between consecutive samples; range 1 .. 2^(WIDTH-1)-1.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `sclr`  in  1  reset, synchronous, active-high.
- `ena`  in  1  sample strobe; `gray_in` is captured on every edge where `ena`=1.
- `gray_in`  in  WIDTH  Gray-coded count.
- `bin_count`  out  WIDTH  decoded binary count of the most recent sample.
- `valid`  out  1  one-cycle pulse: all outputs below reflect a new sample.
- `step`  out  WIDTH  signed difference new − previous, two's complement modulo 2^WIDTH.
- `up`  out  1  1 ≤ step ≤ MAX_STEP.
- `down`  out  1  −MAX_STEP ≤ step ≤ −1.
- `wrap`  out  1  legal up step with new < old, or legal down step with new > old.
- `err`  out  1  |step| > MAX_STEP, or step = −2^(WIDTH-1).
- `err_cnt`  out  16  count of `err` pulses, saturating.
- `locked`  out  1  a reference sample is held.

## Operation
- Decode rule: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i] for i = WIDTH-2 down to 0.
- Stage 1, capture: on `ena`=1 the block registers `g_q` ← `gray_in` and sets `v1` ← 1. Otherwise `v1` ← 0 and `g_q` holds.
- Stage 2, decode and classify: runs when `v1`=1.
  - `bin_count` ← dec(`g_q`).
  - `step` ← dec(`g_q`) − `prev`, where `prev` is the stored binary of the last accepted sample.
  - `prev` ← dec(`g_q`).
- State machine:
  - Two states: EMPTY (`locked`=0) and LOCKED (`locked`=1).
  - EMPTY: the first stage-2 sample sets `prev`, drives `valid`=1 and `step`=0, and keeps up/down/wrap/err at 0. The FSM then moves to LOCKED.
  - LOCKED: every stage-2 sample is classified.
    - Exactly one of hold (step=0), `up`, `down` or `err` applies.
    - `wrap` is only ever set together with `up` or `down`.
  - LOCKED is left only by `sclr`.
- Error samples still update `bin_count` and `prev`, so the block resynchronises to the new value.
- `err_cnt` increments on each `err` pulse and stops at 0xFFFF.
- On a cycle with `v1`=0:
  - `valid`, `up`, `down`, `wrap` and `err` are 0.
  - `bin_count`, `step`, `prev` and `err_cnt` hold.
- Width rules: all arithmetic is WIDTH bits, modulo 2^WIDTH. `step` is interpreted as signed.

## Timing
- Reset values (edge with `sclr`=1):
  - `g_q`=0, `v1`=0, `prev`=0.
  - `bin_count`=0, `step`=0, `valid`=0, `up`=0, `down`=0, `wrap`=0, `err`=0.
  - `err_cnt`=0, `locked`=0, state EMPTY.
- `sclr` has priority over `ena`. A sample presented in the same cycle as `sclr` is dropped.
- Reset mid-operation: a sample sitting in stage 1 is discarded, and no `valid` follows the reset.
- Latency: `gray_in` sampled at edge N (`ena`=1) produces outputs registered at edge N+1, visible in the following cycle.
- Throughput is one sample per clock. Back-to-back `ena` gives back-to-back `valid` pulses.
- `locked` rises on the same edge as the first `valid`.
- `err_cnt` updates on the same edge as `err`.

## Test plan
All scenarios use WIDTH=4, MAX_STEP=1.
- Reset and first sample: `sclr`, then one `ena` with `gray_in`=0111. Response, 2 edges later:
  - `valid`=1, `bin_count`=5, `step`=0, `locked`=1.
  - up/down/err = 0.
- Count up with wrap: feed gray(13), gray(14), gray(15), gray(0) = 1011, 1001, 1000, 0000 back-to-back. Response:
  - `bin_count` = 13, 14, 15, 0.
  - `up`=1 on samples 2–4; `wrap`=1 only on the last sample.
  - `valid` high for 4 consecutive cycles.
- Count down across zero: 0001 (1), 0000 (0), 1000 (15). Response:
  - `down`=1 on samples 2–3; `wrap`=1 only on 0→15.
  - `step`=1111 (−1).
- Illegal jump: after LOCKED at 3 (0010), feed 1101 (9). Response:
  - `err`=1, `step`=0110, `bin_count`=9, `err_cnt`=1.
  - Next sample 1111 (10) gives `up`=1.
- Gaps, hold and step −8: `ena` pattern 1,0,0,1 with equal value 0110 (4).
  - `valid` pulses are 3 cycles apart; the second pulse is a hold (all flags 0); `bin_count` holds in between.
  - Then feed 1000 (15) followed by 0101 (6), step −9 ≡ +7: `err`=1.
  - From LOCKED at 12 (1010), feed 0110 (4): step 1000 (−8), `err`=1.
- Reset priority and saturation:
  - `sclr` and `ena` in the same cycle: no `valid`, `locked`=0.
  - Preload to 0xFFFF by forcing 65535 errors: `err_cnt` stays 0xFFFF on further errors.
